rx_arbiter: RTL and testbench

RX_ARBITER -- requirements
Module: rx_arbiter

---
 rtl/rx_arbiter.sv | 147 ++++++++++++++
 tb/tb_rx_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_arbiter.sv
// rx_arbiter: round-robin read arbiter over NUM_PERIPHS peripheral RX FIFOs,
// with almost-full priority. It forwards whole words, one at a time, to the
// USB transmit path through a valid/ready handshake.
//
// Ports
//   clk, rst        clock; asynchronous active-low reset
//   rx_data         flattened FIFO read data; peripheral i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rx_empty        per-FIFO empty flag
//   rx_almost_full  per-FIFO almost-full flag (raises that FIFO's priority at grant time)
//   rx_read         one-hot FIFO read strobe; data returns one cycle later
//   out_data/out_valid/out_ready   outbound word and its handshake
//   grant_idx       current or most recent grantee
//   busy            FSM is not in IDLE
//
// Words pass through unmodified. Any peripheral address field sits in the top
// bits of each word and is already in place when the word reaches this block.
module rx_arbiter #(
    parameter int NUM_PERIPHS = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int BURST_MAX   = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_PERIPHS*DATA_WIDTH-1:0] rx_data,
    input  logic [NUM_PERIPHS-1:0]            rx_empty,
    input  logic [NUM_PERIPHS-1:0]            rx_almost_full,
    output logic [NUM_PERIPHS-1:0]            rx_read,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [$clog2(NUM_PERIPHS)-1:0]    grant_idx,
    output logic                              busy
);

    localparam int IW = $clog2(NUM_PERIPHS);
    localparam int BW = $clog2(BURST_MAX + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_READ    = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_HOLD    = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [IW-1:0]         grant_q, grant_d;
    logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]         burst_q, burst_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;

    // Round-robin scan starting at rr_ptr. Two winners are tracked in one pass:
    // the first non-empty FIFO that is also almost full, and the first
    // non-empty FIFO of any kind. The almost-full winner takes precedence.
    logic          af_hit, ne_hit;
    logic [IW-1:0] af_idx, ne_idx, scan_idx;

    always_comb begin
        af_hit   = 1'b0;
        ne_hit   = 1'b0;
        af_idx   = '0;
        ne_idx   = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_PERIPHS; k++) begin
            scan_idx = IW'((int'(rr_ptr_q) + k) % NUM_PERIPHS);
            if (!af_hit && rx_almost_full[scan_idx] && !rx_empty[scan_idx]) begin
                af_hit = 1'b1;
                af_idx = scan_idx;
            end
            if (!ne_hit && !rx_empty[scan_idx]) begin
                ne_hit = 1'b1;
                ne_idx = scan_idx;
            end
        end
    end

    logic [IW-1:0] rr_next;
    assign rr_next = (grant_q == IW'(NUM_PERIPHS - 1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        burst_d     = burst_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (af_hit || ne_hit) begin
                    grant_d = af_hit ? af_idx : ne_idx;
                    state_d = S_READ;
                end
            end
            S_READ: state_d = S_CAPTURE;
            S_CAPTURE: begin
                out_data_d  = rx_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
                out_valid_d = 1'b1;
                burst_d     = burst_q + 1'b1;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    // Stay on the grantee only while it has data and burst budget.
                    // Almost-full flags are not consulted here, so a burst is never preempted.
                    if (burst_q < BW'(BURST_MAX) && !rx_empty[grant_q]) begin
                        state_d = S_READ;
                    end else begin
                        rr_ptr_d = rr_next;
                        burst_d  = '0;
                        state_d  = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            burst_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_q     <= burst_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    // The read strobe is decoded from the registered state, so an asynchronous
    // reset removes it at once, without waiting for a clock edge.
    always_comb begin
        rx_read = '0;
        if (state_q == S_READ) rx_read[grant_q] = 1'b1;
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign grant_idx = grant_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_rx_arbiter.sv
// Testbench for rx_arbiter. It models the peripheral FIFOs (one-cycle read
// latency) and keeps a scoreboard of the words expected, in the order
// expected, on the outbound handshake.
module tb_rx_arbiter;
    localparam int NP = 8;
    localparam int DW = 32;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [NP*DW-1:0]   rx_data = '0;
    logic [NP-1:0]      rx_empty = '1;
    logic [NP-1:0]      rx_almost_full = '0;
    logic [NP-1:0]      rx_read;
    logic [DW-1:0]      out_data;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [2:0]         grant_idx;
    logic               busy;

    rx_arbiter #(.NUM_PERIPHS(NP), .DATA_WIDTH(DW), .BURST_MAX(4)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_empty(rx_empty),
        .rx_almost_full(rx_almost_full), .rx_read(rx_read), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .grant_idx(grant_idx), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] d; logic [2:0] p; } exp_t;
    exp_t        sb[$];
    logic [31:0] fq[NP][$];
    int          n_chk = 0, n_err = 0;
    int          acc_cnt = 0;
    int          fall_q[$];
    int          rd_cnt[NP];
    logic        prev_busy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wd(input int p, input int k);
        return {16'hC0DE, 8'(p), 8'(k)};
    endfunction

    task automatic load(input int p, input int n, input int k0);
        for (int j = 0; j < n; j++) fq[p].push_back(wd(p, k0 + j));
    endtask

    task automatic expw(input int p, input int k);
        exp_t e;
        e.d = wd(p, k);
        e.p = 3'(p);
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (sb.size() != 0 && c < 300) begin
            @(negedge clk);
            c++;
        end
        chk("drain_tmo", 32'(sb.size()), 32'(0));
        repeat (3) @(negedge clk);
        chk("back_idle", 32'(busy), 32'(0));
    endtask

    // FIFO model: a read strobe at an edge presents the head word after that edge.
    always @(posedge clk) begin
        for (int i = 0; i < NP; i++) begin
            int sz;
            sz = fq[i].size();
            if (rx_read[i] && sz > 0) begin
                rx_data[i*DW +: DW] <= fq[i].pop_front();
                sz--;
            end
            rx_empty[i] <= (sz == 0);
        end
    end

    // Output monitor and read-strobe protocol checks.
    always @(negedge clk) begin
        if (rst) begin
            if (out_valid && out_ready) begin
                acc_cnt++;
                if (sb.size() == 0) chk("sb_underflow", 32'(1), 32'(0));
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("grant_idx", 32'(grant_idx), 32'(e.p));
                end
            end
            if (rx_read != '0) begin
                chk("rd_onehot", 32'($onehot(rx_read)), 32'(1));
                chk("rd_empty", 32'(|(rx_read & rx_empty)), 32'(0));
                for (int i = 0; i < NP; i++) rd_cnt[i] += int'(rx_read[i]);
            end
            if (prev_busy && !busy) fall_q.push_back(acc_cnt);
        end
        prev_busy = busy;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, r0, c;
        logic [31:0] held;
        for (int i = 0; i < NP; i++) rd_cnt[i] = 0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_rx_read", 32'(rx_read), 32'(0));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_data", out_data, 32'(0));
        chk("rst_grant", 32'(grant_idx), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        step(); rst = 1'b1;

        // all empty: nothing happens
        repeat (20) begin
            @(negedge clk);
            chk("idle_quiet", 32'({busy, rx_read, out_valid}), 32'(0));
        end

        // single peripheral, 6 words, bursts of 4 then 2
        step();
        fall_q.delete(); a0 = acc_cnt;
        load(3, 6, 0);
        for (int k = 0; k < 6; k++) expw(3, k);
        drain();
        chk("p3_nbursts", 32'(fall_q.size()), 32'(2));
        if (fall_q.size() >= 2) begin
            chk("p3_burst1", 32'(fall_q[0] - a0), 32'(4));
            chk("p3_burst2", 32'(fall_q[1] - a0), 32'(6));
        end
        // rr_ptr now 4: P4 wins over P2
        step();
        load(2, 1, 0); load(4, 1, 0);
        expw(4, 0); expw(2, 0);
        drain();

        // P2 empties after 2 words; rr_ptr then 3
        step();
        fall_q.delete(); a0 = acc_cnt; r0 = rd_cnt[2];
        load(2, 2, 1);
        expw(2, 1); expw(2, 2);
        drain();
        chk("p2_reads", 32'(rd_cnt[2] - r0), 32'(2));
        chk("p2_nbursts", 32'(fall_q.size()), 32'(1));
        step();
        load(2, 1, 3); load(3, 1, 6);
        expw(3, 6); expw(2, 3);
        drain();

        // stall in HOLD for 10 cycles
        step();
        out_ready = 1'b0;
        load(6, 2, 0);
        expw(6, 0); expw(6, 1);
        c = 0;
        while (!out_valid && c < 50) begin @(negedge clk); c++; end
        chk("hold_tmo", 32'(out_valid), 32'(1));
        held = out_data;
        chk("hold_word", held, wd(6, 0));
        repeat (10) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'(1));
            chk("hold_data", out_data, held);
            chk("hold_noread", 32'(rx_read), 32'(0));
        end
        step(); out_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("valid_clr", 32'(out_valid), 32'(0));
        drain();

        // reset between READ and CAPTURE, then in HOLD
        step();
        load(0, 3, 0);
        c = 0;
        while (rx_read == '0 && c < 50) begin @(negedge clk); c++; end
        chk("read_p0", 32'(rx_read), 32'(1));
        rst = 1'b0;
        #1;
        chk("arst_rx_read", 32'(rx_read), 32'(0));
        chk("arst_valid", 32'(out_valid), 32'(0));
        chk("arst_busy", 32'(busy), 32'(0));
        step(); rst = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        chk("rel_idle", 32'(busy), 32'(0));
        @(negedge clk);
        chk("first_edge_busy", 32'(busy), 32'(1));
        chk("first_edge_read", 32'(rx_read), 32'(1));
        c = 0;
        while (!out_valid && c < 50) begin @(negedge clk); c++; end
        chk("p0_w0", out_data, wd(0, 0));
        rst = 1'b0;
        #1;
        chk("arst_hold_valid", 32'(out_valid), 32'(0));
        chk("arst_hold_data", out_data, 32'(0));
        chk("arst_hold_grant", 32'(grant_idx), 32'(0));
        step(); rst = 1'b1; out_ready = 1'b1;
        expw(0, 1); expw(0, 2);
        drain();

        // almost-full priority from rr_ptr 0
        step(); rst = 1'b0;
        step(); rst = 1'b1;
        load(1, 3, 0); load(5, 3, 0);
        rx_almost_full = 8'h20;
        for (int k = 0; k < 3; k++) expw(5, k);
        for (int k = 0; k < 3; k++) expw(1, k);
        drain();
        rx_almost_full = '0;

        // almost-full rising mid-burst does not preempt
        step(); rst = 1'b0;
        step(); rst = 1'b1;
        load(1, 3, 4); load(5, 1, 4);
        for (int k = 4; k < 7; k++) expw(1, k);
        expw(5, 4);
        c = 0;
        while (sb.size() > 3 && c < 50) begin @(negedge clk); c++; end
        chk("first_acc_tmo", 32'(sb.size()), 32'(3));
        step(); rx_almost_full = 8'h20;
        drain();
        rx_almost_full = '0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
